// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch front end. Issues one blocking icache request
//             at a time, buffers {pc, instruction} pairs in a prefetch FIFO,
//             hands them to decode over valid/ready and honours redirects by
//             flushing the FIFO and discarding any stale in-flight response.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 'h1000,
  parameter int              FIFO_DEPTH = 4,
  parameter int              CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 icache_access,
  output logic [XLEN-1:0]      icache_address,
  input  logic                 icache_data_ready,
  input  logic [XLEN-1:0]      icache_data_out,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 redirect_misaligned,
  output logic                 fetch_valid,
  input  logic                 fetch_ready,
  output logic [XLEN-1:0]      fetch_pc,
  output logic [XLEN-1:0]      fetch_instruction,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_DROP = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      r_stale_addr;
  logic [XLEN-1:0]      r_pc_mem  [FIFO_DEPTH];
  logic [XLEN-1:0]      r_ins_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_CNT_W-1:0]   w_count_next;
  logic                 r_misaligned;
  logic [CNT_WIDTH-1:0] r_stall;
  logic                 w_push;
  logic                 w_pop;

  // A redirect squashes both the response arriving this cycle and any pop.
  assign w_push = (r_state == c_REQ) && icache_data_ready && !redirect_valid;
  assign w_pop  = fetch_valid && fetch_ready && !redirect_valid;

  assign fetch_valid         = (r_count != '0);
  assign fetch_pc            = r_pc_mem[r_rd_ptr];
  assign fetch_instruction   = r_ins_mem[r_rd_ptr];
  assign icache_access       = (r_state != c_IDLE);
  // DROP keeps presenting the address of the request that is still outstanding.
  assign icache_address      = (r_state == c_DROP) ? r_stale_addr : r_pc;
  assign redirect_misaligned = r_misaligned;
  assign stall_cycles        = r_stall;

  // Occupancy after this cycle's push/pop (ignoring flush).
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_CNT_W'(1);
    end
  end

  // Request sequencing: only request when the response is guaranteed a slot.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (redirect_valid || (r_count < c_DEPTH)) w_state_next = c_REQ;
      end
      c_REQ: begin
        if (redirect_valid) begin
          w_state_next = icache_data_ready ? c_REQ : c_DROP;
        end else if (icache_data_ready) begin
          w_state_next = (w_count_next < c_DEPTH) ? c_REQ : c_IDLE;
        end
      end
      c_DROP: begin
        if (icache_data_ready) w_state_next = c_REQ;
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  // State, fetch PC, stale request address and the misalignment pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_IDLE;
      r_pc         <= RESET_PC;
      r_stale_addr <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid && (r_state == c_REQ) && !icache_data_ready) begin
        r_stale_addr <= r_pc;
      end
      if (redirect_valid) begin
        r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (w_push) begin
        r_pc <= r_pc + XLEN'(4);
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  // FIFO storage; contents are qualified by the count so need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]  <= r_pc;
      r_ins_mem[r_wr_ptr] <= icache_data_out;
    end
  end

  // Saturating count of cycles where decode holds off a valid head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (fetch_valid && !fetch_ready && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire
